output_accumulator: RTL and testbench

//  Downstream of the bias repeater: once the output image region is bias-initialised, adds convolution partial sums into it
//  by read-modify-write on output memory, one pass per input channel.

---
 rtl/cnn_pkg.sv | 21 ++
 rtl/output_accumulator_if.sv | 28 ++
 rtl/acc_sat_add.sv | 26 ++
 rtl/output_accumulator.sv | 154 +++++++++++++++
 tb/tb_output_accumulator.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath package: word sizes, data/address types, accumulator
// FSM states and saturation limits.
package cnn_pkg;

    localparam int unsigned DATA_SZ = 16;
    localparam int unsigned ADDR_SZ = 16;

    typedef logic signed [DATA_SZ-1:0] data_t;
    typedef logic        [ADDR_SZ-1:0] addr_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } acc_state_t;

    localparam data_t SAT_MAX = {1'b0, {(DATA_SZ-1){1'b1}}};
    localparam data_t SAT_MIN = {1'b1, {(DATA_SZ-1){1'b0}}};

endpackage

// File: rtl/output_accumulator_if.sv
// Partial-sum stream and output-memory port bundle of the output accumulator.
// master: the accumulator side; slave: conv engine / memory side.
interface output_accumulator_if;
    import cnn_pkg::*;

    logic  in_valid;
    logic  in_ready;
    data_t in_data;

    logic  mem_rd_en;
    addr_t mem_rd_addr;
    data_t mem_rd_data;

    logic  mem_wr_en;
    addr_t mem_wr_addr;
    data_t mem_wr_data;

    modport master (
        input  in_valid, in_data, mem_rd_data,
        output in_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
    );

    modport slave (
        output in_valid, in_data, mem_rd_data,
        input  in_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
    );

endinterface

// File: rtl/acc_sat_add.sv
// Combinational signed saturating adder with an optional clamp of negative
// results to zero (ReLU).
module acc_sat_add
    import cnn_pkg::*;
(
    input  data_t i_a,
    input  data_t i_b,
    input  logic  i_relu,
    output data_t o_sum
);

    logic [DATA_SZ:0] w_wide;
    data_t            w_sat;

    // Add one bit wider, clamp on overflow, then optionally zero negatives.
    always_comb begin
        w_wide = {i_a[DATA_SZ-1], i_a} + {i_b[DATA_SZ-1], i_b};
        if (w_wide[DATA_SZ] != w_wide[DATA_SZ-1]) begin
            w_sat = w_wide[DATA_SZ] ? SAT_MIN : SAT_MAX;
        end else begin
            w_sat = w_wide[DATA_SZ-1:0];
        end
        o_sum = (i_relu && w_sat[DATA_SZ-1]) ? '0 : w_sat;
    end

endmodule

// File: rtl/output_accumulator.sv
// Output accumulator: adds streamed conv partial sums into a bias-initialised
// output region via a two-stage read-modify-write pipeline, one pass per input
// channel, then pulses done.
// Optional feature macro: ACC_RELU_EN (ReLU clamp on the final pass).
module output_accumulator
    import cnn_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  addr_t                outImgAddress,
    input  data_t                outImgSize,
    input  data_t                numberOfFilters,
    input  data_t                numberOfPasses,
    output_accumulator_if.master acc,
    output logic                 busy,
    output logic                 done
);

    acc_state_t r_state;
    addr_t      r_base;
    addr_t      r_total;
    addr_t      r_pix_idx;
    data_t      r_passes;
    data_t      r_pass_idx;

    // Stage B (write) registers
    logic       r_b_valid;
    addr_t      r_b_addr;
    data_t      r_b_data;
    logic       r_fwd_sel;
    data_t      r_fwd_data;
`ifdef ACC_RELU_EN
    logic       r_b_relu;
`endif

    addr_t      w_total;
    logic       w_accept;
    addr_t      w_a_addr;
    logic       w_last_pix;
    logic       w_last_pass;
    data_t      w_b_old;
    data_t      w_sum;
    logic       w_relu;

    // Config decode and stage A address/handshake
    always_comb begin
        w_total     = addr_t'(outImgSize) * addr_t'(outImgSize) * addr_t'(numberOfFilters);
        w_accept    = acc.in_valid && (r_state == StRun);
        w_a_addr    = r_base + r_pix_idx;
        w_last_pix  = (r_pix_idx == r_total - addr_t'(1));
        w_last_pass = (r_pass_idx == r_passes - data_t'(1));
        // Read-during-write returns old data, so a same-address read issued
        // alongside a write must take the just-written sum instead.
        w_b_old     = r_fwd_sel ? r_fwd_data : acc.mem_rd_data;
    end

`ifdef ACC_RELU_EN
    assign w_relu = r_b_relu;
`else
    assign w_relu = 1'b0;
`endif

    acc_sat_add u_sat_add (
        .i_a    (w_b_old),
        .i_b    (r_b_data),
        .i_relu (w_relu),
        .o_sum  (w_sum)
    );

    // Stream and memory strobes
    always_comb begin
        acc.in_ready    = (r_state == StRun);
        acc.mem_rd_en   = w_accept;
        acc.mem_rd_addr = w_accept ? w_a_addr : '0;
        acc.mem_wr_en   = r_b_valid;
        acc.mem_wr_addr = r_b_addr;
        acc.mem_wr_data = r_b_valid ? w_sum : '0;
        busy            = (r_state != StIdle);
        done            = (r_state == StDone);
    end

    // Layer FSM, pixel/pass counters and stage A -> B pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_base     <= '0;
            r_total    <= '0;
            r_pix_idx  <= '0;
            r_passes   <= '0;
            r_pass_idx <= '0;
            r_b_valid  <= 1'b0;
            r_b_addr   <= '0;
            r_b_data   <= '0;
            r_fwd_sel  <= 1'b0;
            r_fwd_data <= '0;
`ifdef ACC_RELU_EN
            r_b_relu   <= 1'b0;
`endif
        end else begin
            r_b_valid <= w_accept;
            r_fwd_sel <= 1'b0;
            if (w_accept) begin
                r_b_addr   <= w_a_addr;
                r_b_data   <= acc.in_data;
                r_fwd_sel  <= r_b_valid && (r_b_addr == w_a_addr);
                r_fwd_data <= w_sum;
`ifdef ACC_RELU_EN
                r_b_relu   <= w_last_pass;
`endif
                if (w_last_pix) begin
                    r_pix_idx  <= '0;
                    r_pass_idx <= r_pass_idx + data_t'(1);
                end else begin
                    r_pix_idx  <= r_pix_idx + addr_t'(1);
                end
            end

            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_base     <= outImgAddress;
                        r_total    <= w_total;
                        r_passes   <= numberOfPasses;
                        r_pix_idx  <= '0;
                        r_pass_idx <= '0;
                        if (w_total == '0 || numberOfPasses == '0) begin
                            r_state <= StDone;
                        end else begin
                            r_state <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (w_accept && w_last_pix && w_last_pass) begin
                        r_state <= StDrain;
                    end
                end
                StDrain: begin
                    if (r_b_valid) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_accumulator.sv
// Self-checking bench for output_accumulator: table of single-beat vectors
// plus directed multi-cycle sequences against a 1-cycle-latency memory model.
module tb_output_accumulator;
    import cnn_pkg::*;

    typedef struct packed {
        addr_t a;
        data_t d;
    } wr_t;

    typedef struct {
        addr_t base;
        data_t init;
        data_t in;
        data_t exp;
    } vec_t;

    logic  clk = 1'b0;
    logic  reset;
    logic  start;
    addr_t base;
    data_t size;
    data_t filt;
    data_t passes;
    logic  busy;
    logic  done;

    logic  ld_en;
    addr_t ld_addr;
    data_t ld_data;

    int    total = 0;
    int    bad = 0;

    output_accumulator_if bus ();

    output_accumulator dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .outImgAddress   (base),
        .outImgSize      (size),
        .numberOfFilters (filt),
        .numberOfPasses  (passes),
        .acc             (bus),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // Output memory: 1-cycle read latency, read-during-write returns old data
    data_t mem [65536];
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
        if (bus.mem_wr_en) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    // Monitor, sampled mid-cycle
    wr_t wlog[$];
    int  cyc = 0;
    int  last_wr_cyc = 0;
    int  done_cyc = 0;
    int  done_cnt = 0;
    int  rd_cnt = 0;
    always @(negedge clk) begin
        cyc++;
        if (bus.mem_wr_en) begin
            wlog.push_back({bus.mem_wr_addr, bus.mem_wr_data});
            last_wr_cyc = cyc;
        end
        if (bus.mem_rd_en) rd_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic data_t fin(input data_t v);
`ifdef ACC_RELU_EN
        return (v < 0) ? data_t'(0) : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input addr_t a, input data_t d);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic do_start(input addr_t b, input data_t sz, input data_t fl, input data_t ps);
        base = b;
        size = sz;
        filt = fl;
        passes = ps;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 200) begin
            tick();
            k++;
        end
    endtask

    task automatic send_beat(input string nm, input data_t d, input bit gap);
        int k;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) begin
            total++;
            bad++;
            $display("FAIL %s ready timeout: got 0 expected 1", nm);
        end
        tick();
        if (gap) begin
            bus.in_valid = 1'b0;
            tick();
        end
    endtask

    task automatic run_layer(input string nm, input addr_t b, input data_t sz, input data_t fl,
                             input data_t ps, input data_t beats[$], input bit gap,
                             input bit hold, input wr_t exp[$]);
        int w0;
        int d0;
        int r0;
        w0 = wlog.size();
        d0 = done_cnt;
        r0 = rd_cnt;
        do_start(b, sz, fl, ps);
        foreach (beats[i]) send_beat(nm, beats[i], gap);
        // hold: keep offering a beat through drain to show it is never taken
        if (!hold) bus.in_valid = 1'b0;
        wait_done(d0);
        bus.in_valid = 1'b0;
        repeat (2) tick();
        chk($sformatf("%s wr_count", nm), wlog.size() - w0, exp.size());
        foreach (exp[i]) begin
            if (w0 + i < wlog.size()) begin
                chk($sformatf("%s wr_addr[%0d]", nm, i), int'(wlog[w0+i].a), int'(exp[i].a));
                chk($sformatf("%s wr_data[%0d]", nm, i), int'(wlog[w0+i].d), int'(exp[i].d));
            end
        end
        chk($sformatf("%s done_count", nm), done_cnt - d0, 1);
        chk($sformatf("%s rd_count", nm), rd_cnt - r0, beats.size());
        if (exp.size() > 0) chk($sformatf("%s done_latency", nm), done_cyc - last_wr_cyc, 1);
    endtask

    vec_t  vt[6];
    data_t bq[$];
    wr_t   eq[$];

    initial begin
        int w0;
        int d0;
        int r0;

        vt[0] = '{base: 16'h0100, init: 16'sd5,      in: 16'sd1,     exp: 16'sd6};
        vt[1] = '{base: 16'h0200, init: 16'sd32000,  in: 16'sd1000,  exp: 16'sd32767};
        vt[2] = '{base: 16'h0300, init: -16'sd32000, in: -16'sd1000, exp: fin(-16'sd32768)};
        vt[3] = '{base: 16'h0400, init: -16'sd5,     in: -16'sd3,    exp: fin(-16'sd8)};
        vt[4] = '{base: 16'h0500, init: 16'sd32767,  in: -16'sd1,    exp: 16'sd32766};
        vt[5] = '{base: 16'h0600, init: -16'sd32768, in: 16'sd32767, exp: fin(-16'sd1)};

        reset = 1'b1;
        start = 1'b0;
        base = '0;
        size = '0;
        filt = '0;
        passes = '0;
        ld_en = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        repeat (3) tick();

        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset in_ready", int'(bus.in_ready), 0);
        chk("reset wr_en", int'(bus.mem_wr_en), 0);
        chk("reset rd_en", int'(bus.mem_rd_en), 0);
        reset = 1'b0;
        tick();

        // Single-beat saturation/sum table
        for (int i = 0; i < 6; i++) begin
            preload(vt[i].base, vt[i].init);
            bq = {};
            eq = {};
            bq.push_back(vt[i].in);
            eq.push_back('{a: vt[i].base, d: vt[i].exp});
            run_layer($sformatf("vec%0d", i), vt[i].base, 16'sd1, 16'sd1, 16'sd1, bq, 1'b0, 1'b0,
                      eq);
        end

        // 2x2, one pass, back-to-back, extra beat held during drain
        for (int i = 0; i < 4; i++) preload(addr_t'(16'h1000 + i), 16'sd5);
        bq = {};
        eq = {};
        for (int i = 0; i < 4; i++) begin
            bq.push_back(data_t'(i + 1));
            eq.push_back('{a: addr_t'(16'h1000 + i), d: data_t'(i + 6)});
        end
        run_layer("basic", 16'h1000, 16'sd2, 16'sd1, 16'sd1, bq, 1'b0, 1'b1, eq);

        // TOTAL=1, three passes back-to-back: forwarding
        preload(16'h2000, 16'sd10);
        bq = {};
        eq = {};
        for (int i = 0; i < 3; i++) begin
            bq.push_back(16'sd1);
            eq.push_back('{a: 16'h2000, d: data_t'(11 + i)});
        end
        run_layer("fwd", 16'h2000, 16'sd1, 16'sd1, 16'sd3, bq, 1'b0, 1'b0, eq);

        // TOTAL=2, two passes: second pass reads first pass results from memory
        preload(16'h2100, 16'sd10);
        preload(16'h2101, 16'sd20);
        bq = {};
        eq = {};
        for (int i = 0; i < 4; i++) bq.push_back(data_t'(i + 1));
        eq.push_back('{a: 16'h2100, d: 16'sd11});
        eq.push_back('{a: 16'h2101, d: 16'sd22});
        eq.push_back('{a: 16'h2100, d: 16'sd14});
        eq.push_back('{a: 16'h2101, d: 16'sd26});
        run_layer("twopass", 16'h2100, 16'sd1, 16'sd2, 16'sd2, bq, 1'b0, 1'b0, eq);

        // ReLU only on final pass
        preload(16'h3000, 16'sd0);
        bq = {};
        eq = {};
        bq.push_back(-16'sd5);
        bq.push_back(-16'sd3);
        eq.push_back('{a: 16'h3000, d: -16'sd5});
        eq.push_back('{a: 16'h3000, d: fin(-16'sd8)});
        run_layer("relu", 16'h3000, 16'sd1, 16'sd1, 16'sd2, bq, 1'b0, 1'b0, eq);

        // Address wrap with gapped valid
        for (int i = 0; i < 4; i++) preload(addr_t'(16'hFFFE + i), data_t'(100 * (i + 1)));
        bq = {};
        eq = {};
        for (int i = 0; i < 4; i++) begin
            bq.push_back(data_t'(i + 1));
            eq.push_back('{a: addr_t'(16'hFFFE + i), d: data_t'(101 * (i + 1))});
        end
        run_layer("wrap", 16'hFFFE, 16'sd2, 16'sd1, 16'sd1, bq, 1'b1, 1'b0, eq);

        // Degenerate layers: no memory access, done one cycle after start
        for (int i = 0; i < 2; i++) begin
            w0 = wlog.size();
            d0 = done_cnt;
            r0 = rd_cnt;
            if (i == 0) do_start(16'h0700, 16'sd2, 16'sd1, 16'sd0);
            else do_start(16'h0700, 16'sd0, 16'sd3, 16'sd2);
            chk($sformatf("empty%0d done", i), int'(done), 1);
            repeat (3) tick();
            chk($sformatf("empty%0d done_count", i), done_cnt - d0, 1);
            chk($sformatf("empty%0d wr_count", i), wlog.size() - w0, 0);
            chk($sformatf("empty%0d rd_count", i), rd_cnt - r0, 0);
        end

        // start while busy is ignored; config inputs change mid-layer
        preload(16'h4000, 16'sd7);
        preload(16'h4001, 16'sd8);
        w0 = wlog.size();
        d0 = done_cnt;
        do_start(16'h4000, 16'sd1, 16'sd2, 16'sd1);
        base = 16'h5000;
        size = 16'sd3;
        passes = 16'sd0;
        start = 1'b1;
        send_beat("busy", 16'sd1, 1'b0);
        start = 1'b0;
        send_beat("busy", 16'sd1, 1'b0);
        bus.in_valid = 1'b0;
        wait_done(d0);
        repeat (3) tick();
        chk("busy wr_count", wlog.size() - w0, 2);
        if (wlog.size() - w0 == 2) begin
            chk("busy wr_addr0", int'(wlog[w0].a), 16'h4000);
            chk("busy wr_data0", int'(wlog[w0].d), 8);
            chk("busy wr_addr1", int'(wlog[w0+1].a), 16'h4001);
            chk("busy wr_data1", int'(wlog[w0+1].d), 9);
        end
        chk("busy done_count", done_cnt - d0, 1);

        // Reset in the middle of a layer aborts it
        d0 = done_cnt;
        do_start(16'h6000, 16'sd2, 16'sd1, 16'sd1);
        bus.in_valid = 1'b1;
        bus.in_data = 16'sd1;
        tick();
        reset = 1'b1;
        tick();
        w0 = wlog.size();
        chk("abort wr_en", int'(bus.mem_wr_en), 0);
        chk("abort rd_en", int'(bus.mem_rd_en), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        reset = 1'b0;
        repeat (6) tick();
        bus.in_valid = 1'b0;
        chk("abort done_count", done_cnt - d0, 0);
        chk("abort wr_count", wlog.size() - w0, 0);
        chk("abort in_ready", int'(bus.in_ready), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
